// File: rtl/motion_cmd_arbiter_if.sv
// Command-bus bundle between the motion command arbiter and its requesters/decoder.
// The arbiter takes the master modport; requesters and the decoder take the slave modport.
interface motion_cmd_arbiter_if;
   logic [7:0] host_key;
   logic       host_valid;
   logic [7:0] auto_key;
   logic       auto_valid;
   logic [7:0] cmd_out;
   logic       cmd_strobe;
   logic [1:0] owner;
   logic       auto_en;

   modport master (
      input  host_key,
      input  host_valid,
      input  auto_key,
      input  auto_valid,
      output cmd_out,
      output cmd_strobe,
      output owner,
      output auto_en
   );

   modport slave (
      output host_key,
      output host_valid,
      output auto_key,
      output auto_valid,
      input  cmd_out,
      input  cmd_strobe,
      input  owner,
      input  auto_en
   );
endinterface

// File: rtl/motion_cmd_arbiter.sv
// Priority arbiter (ALARM > HOST > AUTO) for the 8-bit motion command bus, with gas debounce,
// host watchdog and alarm hold. Define ARB_STATS_EN to add the preempt_cnt output.
module motion_cmd_arbiter #(
   parameter int unsigned GAS_DEB_CYC    = 500_000,
   parameter int unsigned ALARM_HOLD_CYC = 25_000_000,
   parameter int unsigned HOST_TMO_CYC   = 100_000_000,
   parameter logic [7:0]  IDLE_CODE      = 8'd17,
   parameter logic [7:0]  ALARM_CODE     = 8'd16,
   parameter logic [7:0]  TOGGLE_CODE    = 8'd15
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 gas_n,
   motion_cmd_arbiter_if.master bus
`ifdef ARB_STATS_EN
   ,
   output logic [15:0]          preempt_cnt
`endif
);

   localparam int unsigned DEB_W  = (GAS_DEB_CYC > 1)    ? $clog2(GAS_DEB_CYC)    : 1;
   localparam int unsigned HOLD_W = (ALARM_HOLD_CYC > 1) ? $clog2(ALARM_HOLD_CYC) : 1;
   localparam int unsigned WDOG_W = (HOST_TMO_CYC > 1)   ? $clog2(HOST_TMO_CYC)   : 1;

   localparam logic [DEB_W-1:0]  DEB_MAX  = DEB_W'(GAS_DEB_CYC - 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(ALARM_HOLD_CYC - 1);
   localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(HOST_TMO_CYC - 1);

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StAuto  = 2'd1,
      StHost  = 2'd2,
      StAlarm = 2'd3
   } state_e;

   logic             gas_meta, gas_sync, gas_alarm;
   logic [DEB_W-1:0] deb_cnt;

   state_e            state_q;
   logic [7:0]        cmd_q;
   logic              strobe_q;
   logic              auto_en_q;
   logic [WDOG_W-1:0] wdog_q;
   logic [HOLD_W-1:0] hold_q;

   logic host_req, host_tog, auto_en_nx, auto_req, enter_alarm;

   // Synchronise the raw sensor; it idles high (no smoke), so reset the stages high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gas_meta  <= 1'b1;
         gas_sync  <= 1'b1;
         gas_alarm <= 1'b0;
         deb_cnt   <= '0;
      end else begin
         gas_meta <= gas_n;
         gas_sync <= gas_meta;
         if (!gas_sync != gas_alarm) begin
            if (deb_cnt == DEB_MAX) begin
               gas_alarm <= !gas_sync;
               deb_cnt   <= '0;
            end else begin
               deb_cnt <= deb_cnt + DEB_W'(1);
            end
         end else begin
            deb_cnt <= '0;
         end
      end
   end

   assign host_tog    = bus.host_valid && (bus.host_key == TOGGLE_CODE);
   assign host_req    = bus.host_valid && (bus.host_key != TOGGLE_CODE);
   // A toggle in the same cycle decides whether an IDLE auto request is accepted.
   assign auto_en_nx  = auto_en_q ^ host_tog;
   assign auto_req    = bus.auto_valid && (bus.auto_key != IDLE_CODE);
   assign enter_alarm = gas_alarm && (state_q != StAlarm);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         cmd_q     <= IDLE_CODE;
         strobe_q  <= 1'b0;
         auto_en_q <= 1'b0;
         wdog_q    <= '0;
         hold_q    <= '0;
      end else begin
         strobe_q <= 1'b0;
         if (enter_alarm) begin
            // Alarm wins over everything; any request in this cycle is dropped.
            state_q  <= StAlarm;
            cmd_q    <= ALARM_CODE;
            strobe_q <= 1'b1;
            hold_q   <= '0;
            wdog_q   <= '0;
         end else begin
            case (state_q)
               StIdle: begin
                  if (host_tog) auto_en_q <= ~auto_en_q;
                  if (host_req) begin
                     state_q  <= StHost;
                     cmd_q    <= bus.host_key;
                     strobe_q <= 1'b1;
                     wdog_q   <= '0;
                  end else if (auto_en_nx && auto_req) begin
                     state_q  <= StAuto;
                     cmd_q    <= bus.auto_key;
                     strobe_q <= 1'b1;
                  end
               end
               StHost: begin
                  if (bus.host_valid) begin
                     wdog_q <= '0;
                     if (host_tog) begin
                        auto_en_q <= ~auto_en_q;
                     end else begin
                        cmd_q    <= bus.host_key;
                        strobe_q <= 1'b1;
                        if (bus.host_key == IDLE_CODE) state_q <= StIdle;
                     end
                  end else if (wdog_q == WDOG_MAX) begin
                     state_q  <= StIdle;
                     cmd_q    <= IDLE_CODE;
                     strobe_q <= 1'b1;
                     wdog_q   <= '0;
                  end else begin
                     wdog_q <= wdog_q + WDOG_W'(1);
                  end
               end
               StAuto: begin
                  if (host_req) begin
                     state_q  <= StHost;
                     cmd_q    <= bus.host_key;
                     strobe_q <= 1'b1;
                     wdog_q   <= '0;
                  end else if (host_tog) begin
                     // auto_en is always set while AUTO owns the bus, so a toggle clears it.
                     auto_en_q <= ~auto_en_q;
                     state_q   <= StIdle;
                     cmd_q     <= IDLE_CODE;
                     strobe_q  <= 1'b1;
                  end else if (bus.auto_valid) begin
                     cmd_q    <= bus.auto_key;
                     strobe_q <= 1'b1;
                     if (bus.auto_key == IDLE_CODE) state_q <= StIdle;
                  end
               end
               StAlarm: begin
                  if (hold_q != HOLD_MAX) hold_q <= hold_q + HOLD_W'(1);
                  if (!gas_alarm && (hold_q == HOLD_MAX)) begin
                     state_q  <= StIdle;
                     cmd_q    <= IDLE_CODE;
                     strobe_q <= 1'b1;
                  end
               end
            endcase
         end
      end
   end

   assign bus.owner      = state_q;
   assign bus.cmd_out    = cmd_q;
   assign bus.cmd_strobe = strobe_q;
   assign bus.auto_en    = auto_en_q;

`ifdef ARB_STATS_EN
   logic preempt;

   // Every entry into ALARM counts, as does HOST taking the bus away from AUTO.
   assign preempt = enter_alarm || ((state_q == StAuto) && !gas_alarm && host_req);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         preempt_cnt <= 16'd0;
      end else if (preempt && (preempt_cnt != 16'hFFFF)) begin
         preempt_cnt <= preempt_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_motion_cmd_arbiter.sv
// Bench for motion_cmd_arbiter: directed scenarios plus random traffic against a
// transaction-level reference model of the arbitration rules.
module tb_motion_cmd_arbiter;
   localparam int unsigned DEB  = 4;
   localparam int unsigned HOLD = 20;
   localparam int unsigned TMO  = 50;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic gas_n = 1'b1;
   int   checks = 0;
   int   errors = 0;

   motion_cmd_arbiter_if bus ();
`ifdef ARB_STATS_EN
   logic [15:0] preempt_cnt;
`endif

   motion_cmd_arbiter #(
      .GAS_DEB_CYC   (DEB),
      .ALARM_HOLD_CYC(HOLD),
      .HOST_TMO_CYC  (TMO)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .gas_n(gas_n),
      .bus  (bus)
`ifdef ARB_STATS_EN
      ,
      .preempt_cnt(preempt_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Reference model: owner 0 idle, 1 auto, 2 host, 3 alarm.
   int         m_owner, m_deb, m_quiet, m_held;
   logic [7:0] m_cmd;
   logic       m_strobe, m_aen, m_alarm, m_s1, m_s2;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_owner = 0; m_deb = 0; m_quiet = 0; m_held = 0;
      m_cmd = 8'd17; m_strobe = 1'b0; m_aen = 1'b0; m_alarm = 1'b0;
      m_s1 = 1'b1; m_s2 = 1'b1;
   endtask

   task automatic model_step();
      logic       hv, av, tog, hreq, lvl;
      logic [7:0] hk, ak;
      hv = bus.host_valid; hk = bus.host_key; av = bus.auto_valid; ak = bus.auto_key;
      tog  = hv && (hk == 8'd15);
      hreq = hv && (hk != 8'd15);
      m_strobe = 1'b0;
      if (m_alarm && m_owner != 3) begin
         m_owner = 3; m_cmd = 8'd16; m_strobe = 1'b1; m_held = 0;
      end else begin
         case (m_owner)
            0: begin
               if (tog) m_aen = !m_aen;
               if (hreq) begin
                  m_owner = 2; m_cmd = hk; m_strobe = 1'b1; m_quiet = 0;
               end else if (m_aen && av && ak != 8'd17) begin
                  m_owner = 1; m_cmd = ak; m_strobe = 1'b1;
               end
            end
            2: begin
               if (hv) begin
                  m_quiet = 0;
                  if (tog) m_aen = !m_aen;
                  else begin
                     m_cmd = hk; m_strobe = 1'b1;
                     if (hk == 8'd17) m_owner = 0;
                  end
               end else begin
                  m_quiet++;
                  if (m_quiet == TMO) begin m_owner = 0; m_cmd = 8'd17; m_strobe = 1'b1; end
               end
            end
            1: begin
               if (hreq) begin
                  m_owner = 2; m_cmd = hk; m_strobe = 1'b1; m_quiet = 0;
               end else if (tog) begin
                  m_aen = !m_aen; m_owner = 0; m_cmd = 8'd17; m_strobe = 1'b1;
               end else if (av) begin
                  m_cmd = ak; m_strobe = 1'b1;
                  if (ak == 8'd17) m_owner = 0;
               end
            end
            default: begin
               m_held++;
               if (!m_alarm && m_held >= HOLD) begin
                  m_owner = 0; m_cmd = 8'd17; m_strobe = 1'b1;
               end
            end
         endcase
      end
      // Debounced alarm: needs DEB consecutive cycles of disagreement to flip.
      lvl = !m_s2;
      if (lvl != m_alarm) begin
         m_deb++;
         if (m_deb == DEB) begin m_alarm = lvl; m_deb = 0; end
      end else begin
         m_deb = 0;
      end
      m_s2 = m_s1;
      m_s1 = gas_n;
   endtask

   task automatic tick(input string tag);
      model_step();
      @(posedge clk);
      #1;
      chk({tag, ".cmd"},    bus.cmd_out,    m_cmd);
      chk({tag, ".strobe"}, bus.cmd_strobe, m_strobe);
      chk({tag, ".owner"},  bus.owner,      m_owner[1:0]);
      chk({tag, ".auto_en"}, bus.auto_en,   m_aen);
   endtask

   task automatic cyc(input logic hv, input logic [7:0] hk, input logic av,
                      input logic [7:0] ak, input string tag);
      bus.host_valid = hv; bus.host_key = hk;
      bus.auto_valid = av; bus.auto_key = ak;
      tick(tag);
   endtask

   task automatic idle(input int n, input string tag);
      for (int i = 0; i < n; i++) cyc(1'b0, 8'd0, 1'b0, 8'd0, tag);
   endtask

   initial begin
      int         len;
      logic       aen_save;
      int         gas_run;
      logic [7:0] hkeys [6];
      logic [7:0] akeys [4];
      hkeys = '{8'd3, 8'd5, 8'd7, 8'd9, 8'd15, 8'd17};
      akeys = '{8'd5, 8'd6, 8'd17, 8'd2};
      bus.host_valid = 1'b0; bus.host_key = 8'd0;
      bus.auto_valid = 1'b0; bus.auto_key = 8'd0;
      model_reset();

      // Reset values
      #7;
      chk("rst.cmd", bus.cmd_out, 8'd17);
      chk("rst.strobe", bus.cmd_strobe, 1'b0);
      chk("rst.owner", bus.owner, 2'd0);
      chk("rst.auto_en", bus.auto_en, 1'b0);
`ifdef ARB_STATS_EN
      chk("rst.preempt_lo", preempt_cnt[7:0], 8'd0);
`endif
      #5 rst_n = 1'b1;
      idle(3, "post_rst");

      // Host grant and watchdog release
      cyc(1'b1, 8'd3, 1'b0, 8'd0, "host3");
      chk("host3.cmd_c", bus.cmd_out, 8'd3);
      chk("host3.owner_c", bus.owner, 2'd2);
      chk("host3.strobe_c", bus.cmd_strobe, 1'b1);
      idle(TMO - 1, "wdog");
      chk("wdog_edge.owner_c", bus.owner, 2'd2);
      idle(1, "wdog_exp");
      chk("wdog_exp.owner_c", bus.owner, 2'd0);
      chk("wdog_exp.cmd_c", bus.cmd_out, 8'd17);

      // Toggle auto, auto grant, host preempt
      cyc(1'b1, 8'd15, 1'b0, 8'd0, "tog");
      chk("tog.auto_en_c", bus.auto_en, 1'b1);
      cyc(1'b0, 8'd0, 1'b1, 8'd5, "auto5");
      chk("auto5.owner_c", bus.owner, 2'd1);
      chk("auto5.cmd_c", bus.cmd_out, 8'd5);
      cyc(1'b1, 8'd7, 1'b0, 8'd0, "host7");
      chk("host7.owner_c", bus.owner, 2'd2);
      chk("host7.cmd_c", bus.cmd_out, 8'd7);
      cyc(1'b1, 8'd17, 1'b0, 8'd0, "host_rel");

      // Gas glitch then real alarm with hold
      gas_n = 1'b0; idle(3, "glitch");
      gas_n = 1'b1; idle(10, "glitch_after");
      chk("glitch.owner_c", bus.owner, 2'd0);
      gas_n = 1'b0;
      for (int i = 0; i < 12 && bus.owner != 2'd3; i++) idle(1, "gas_in");
      chk("alarm.owner_c", bus.owner, 2'd3);
      chk("alarm.cmd_c", bus.cmd_out, 8'd16);
      idle(5, "hold5");
      gas_n = 1'b1;
      len = 5;
      for (int i = 0; i < 60 && bus.owner == 2'd3; i++) begin idle(1, "hold"); len++; end
      chk("alarm_exit.owner_c", bus.owner, 2'd0);
      chk("alarm_exit.cmd_c", bus.cmd_out, 8'd17);
      chk("alarm_len", 8'(len), 8'(HOLD));

      // Same-cycle host and auto with auto enabled
      cyc(1'b1, 8'd9, 1'b1, 8'd5, "host_auto");
      chk("host_auto.cmd_c", bus.cmd_out, 8'd9);
      chk("host_auto.owner_c", bus.owner, 2'd2);
      cyc(1'b1, 8'd17, 1'b0, 8'd0, "host_rel2");

      // Requests dropped during alarm
      gas_n = 1'b0;
      for (int i = 0; i < 12 && bus.owner != 2'd3; i++) idle(1, "gas_in2");
      aen_save = bus.auto_en;
      cyc(1'b1, 8'd15, 1'b0, 8'd0, "alarm_tog");
      cyc(1'b1, 8'd3, 1'b1, 8'd5, "alarm_key");
      chk("alarm_drop.auto_en_c", bus.auto_en, aen_save);
      chk("alarm_drop.cmd_c", bus.cmd_out, 8'd16);
      chk("alarm_drop.strobe_c", bus.cmd_strobe, 1'b0);
      gas_n = 1'b1;
      for (int i = 0; i < 60 && bus.owner == 2'd3; i++) idle(1, "drain");

      // Toggle clearing auto_en with same-cycle auto request in IDLE
      if (!m_aen) cyc(1'b1, 8'd15, 1'b0, 8'd0, "tog_set");
      cyc(1'b1, 8'd15, 1'b1, 8'd5, "tog_clr_auto");
      chk("tog_clr_auto.owner_c", bus.owner, 2'd0);
      chk("tog_clr_auto.auto_en_c", bus.auto_en, 1'b0);

      // Random traffic
      gas_run = 100;
      for (int n = 0; n < 2500; n++) begin
         logic       hv, av;
         logic [7:0] hk, ak;
         int         idx;
         if (gas_run == 0) begin
            gas_n = ~gas_n;
            gas_run = gas_n ? $urandom_range(20, 200) : $urandom_range(1, 12);
         end
         gas_run--;
         hv  = ($urandom_range(0, 7) == 0);
         idx = $urandom_range(0, 6);
         hk  = (idx == 6) ? 8'($urandom_range(0, 255)) : hkeys[idx];
         av  = ($urandom_range(0, 3) == 0);
         idx = $urandom_range(0, 4);
         ak  = (idx == 4) ? 8'($urandom_range(0, 255)) : akeys[idx];
         cyc(hv, hk, av, ak, "rnd");
      end

      // Asynchronous reset while HOST owns the bus
      gas_n = 1'b1;
      idle(80, "settle");
      cyc(1'b1, 8'd3, 1'b0, 8'd0, "pre_rst");
      chk("pre_rst.owner_c", bus.owner, 2'd2);
      idle(1, "pre_rst2");
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst.cmd", bus.cmd_out, 8'd17);
      chk("async_rst.owner", bus.owner, 2'd0);
      chk("async_rst.auto_en", bus.auto_en, 1'b0);
      chk("async_rst.strobe", bus.cmd_strobe, 1'b0);
`ifdef ARB_STATS_EN
      chk("async_rst.preempt_lo", preempt_cnt[7:0], 8'd0);
      chk("async_rst.preempt_hi", preempt_cnt[15:8], 8'd0);
`endif
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      idle(5, "no_replay");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
